// File: rtl/cover_toggle_scheduler.sv
// Toggle-coverage report scheduler.
// Each toggle point owns a covered bit and a pending bit. A point is reported
// once per reset/clear epoch. The lowest-indexed pending point is loaded into
// a single registered output slot, which follows a valid/ready handshake.

// One toggle point: its covered and pending state bits.
module cover_toggle_cell (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic hit,      // valid bit already gated by enable
    input  logic grant,    // this point is being loaded into the output slot
    output logic covered,
    output logic pending,
    output logic new_hit
);
    // Once covered, a point never queues again, so re-hits are deduplicated here.
    assign new_hit = hit & ~covered & ~clear;

    // Covered is sticky; pending is set by a first hit and cleared by a grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            covered <= 1'b0;
            pending <= 1'b0;
        end else if (clear) begin
            covered <= 1'b0;
            pending <= 1'b0;
        end else begin
            covered <= covered | new_hit;
            pending <= (pending & ~grant) | new_hit;
        end
    end
endmodule

module cover_toggle_scheduler #(
    parameter int WIDTH       = 28,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 10906
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] valid,
    input  logic             enable,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_index,
    output logic [15:0]      covered_count,
    output logic             all_covered,
    output logic             busy
);
    // This instance's points must fit inside the global cover index space.
    generate
        if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_err
            $error("cover_toggle_scheduler: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
        end
    endgenerate

    logic [WIDTH-1:0] covered;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] new_hits;
    logic [WIDTH-1:0] grant;
    logic [WIDTH-1:0] cov_next;
    logic             load;
    logic             any_pending;
    logic [31:0]      pick_idx;
    logic [15:0]      count_next;

    // Per-point state, one cell per toggle point.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            cover_toggle_cell u_cell (
                .clock   (clock),
                .reset   (reset),
                .clear   (clear),
                .hit     (valid[i] & enable),
                .grant   (grant[i]),
                .covered (covered[i]),
                .pending (pending[i]),
                .new_hit (new_hits[i])
            );
        end
    endgenerate

    // The slot can take a new report when empty or when the current one is accepted.
    assign load = ~out_valid | out_ready;

    // Lowest-indexed pending point wins; grant is one-hot only on a loading edge.
    always_comb begin
        any_pending = 1'b0;
        pick_idx    = '0;
        grant       = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                any_pending = 1'b1;
                pick_idx    = 32'(i);
            end
        end
        if (load && any_pending && !clear)
            grant[pick_idx] = 1'b1;
    end

    // Coverage bitmap as it will be after this edge, for the registered summaries.
    always_comb begin
        cov_next   = covered | new_hits;
        count_next = '0;
        for (int i = 0; i < WIDTH; i++)
            count_next = count_next + 16'(cov_next[i]);
    end

    // Output slot: load the granted point, go idle when nothing is pending,
    // hold while stalled. Clear drops an in-flight report without a handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_index <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_index <= '0;
        end else if (load) begin
            if (any_pending) begin
                out_valid <= 1'b1;
                out_index <= 64'(COVER_INDEX) + 64'(pick_idx);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Coverage summaries registered on the same edge as the covered bitmap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            covered_count <= '0;
            all_covered   <= 1'b0;
        end else if (clear) begin
            covered_count <= '0;
            all_covered   <= 1'b0;
        end else begin
            covered_count <= count_next;
            all_covered   <= &cov_next;
        end
    end

    assign busy = (|pending) | out_valid;
endmodule

// File: tb/tb_cover_toggle_scheduler.sv
// Randomized and directed bench for cover_toggle_scheduler with a
// set/queue-based reference model of the reporting behaviour.
module tb_cover_toggle_scheduler;
    localparam int W  = 28;
    localparam int CI = 100;

    logic          clock = 1'b0;
    logic          reset;
    logic [W-1:0]  valid;
    logic          enable;
    logic          clear;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_index;
    logic [15:0]   covered_count;
    logic          all_covered;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: covered set, queue of waiting point numbers, one slot.
    logic [W-1:0] m_cov;
    int           m_pend[$];
    logic         m_vld;
    longint       m_idx;

    cover_toggle_scheduler #(.WIDTH(W), .COVER_INDEX(CI), .COVER_TOTAL(10906)) dut (
        .clock         (clock),
        .reset         (reset),
        .valid         (valid),
        .enable        (enable),
        .clear         (clear),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_index     (out_index),
        .covered_count (covered_count),
        .all_covered   (all_covered),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cov = '0;
        m_pend.delete();
        m_vld = 1'b0;
        m_idx = 0;
    endtask

    // One clock edge of the behavioural rules, using the inputs held this cycle.
    task automatic model_step();
        int best, pos;
        if (reset) begin model_reset(); return; end
        if (clear) begin
            m_cov = '0; m_pend.delete(); m_vld = 1'b0;
            return;
        end
        if (!m_vld || out_ready) begin
            if (m_pend.size() > 0) begin
                best = m_pend[0]; pos = 0;
                foreach (m_pend[j]) if (m_pend[j] < best) begin best = m_pend[j]; pos = j; end
                m_pend.delete(pos);
                m_vld = 1'b1;
                m_idx = CI + best;
            end else begin
                m_vld = 1'b0;
            end
        end
        if (enable)
            for (int i = 0; i < W; i++)
                if (valid[i] && !m_cov[i]) begin
                    m_cov[i] = 1'b1;
                    m_pend.push_back(i);
                end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_vld));
        if (m_vld) chk({tag, ".out_index"}, out_index, 64'(m_idx));
        chk({tag, ".covered_count"}, 64'(covered_count), 64'($countones(m_cov)));
        chk({tag, ".all_covered"}, 64'(all_covered), 64'(m_cov == '1));
        chk({tag, ".busy"}, 64'(busy), 64'((m_pend.size() != 0) || m_vld));
    endtask

    // Advance one edge, update model, then sample outputs 1 time unit later.
    task automatic tick(input string tag);
        @(posedge clock);
        model_step();
        #1;
        compare_all(tag);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int k = 0; k < n; k++) tick(tag);
    endtask

    task automatic do_clear();
        clear = 1'b1; valid = '0;
        tick("clear");
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; valid = '0; enable = 1'b1; clear = 1'b0; out_ready = 1'b1;
        model_reset();
        #12;
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.out_index", out_index, 64'd0);
        chk("reset.covered_count", 64'(covered_count), 64'd0);
        chk("reset.all_covered", 64'(all_covered), 64'd0);
        chk("reset.busy", 64'(busy), 64'd0);
        tick("reset_hold");
        reset = 1'b0;
        ticks("post_reset", 2);

        // Single hit.
        valid = 28'h0000010; tick("single");
        valid = '0; ticks("single", 4);

        // Burst, reported in ascending order.
        do_clear();
        valid = 28'h8000005; tick("burst");
        valid = '0; ticks("burst", 5);

        // Backpressure with repeated hits.
        do_clear();
        out_ready = 1'b0; valid = 28'h3;
        ticks("bp", 5);
        valid = '0; out_ready = 1'b1;
        ticks("bp_drain", 4);

        // Full coverage then re-hits.
        do_clear();
        valid = 28'hFFFFFFF; tick("full");
        valid = '0; ticks("full", 31);
        valid = 28'hFFFFFFF; ticks("full_rehit", 3);
        valid = '0;

        // Clear mid-drain, then re-hit one point.
        do_clear();
        valid = 28'h00000F0; tick("mid");
        valid = '0; ticks("mid", 2);
        do_clear();
        ticks("mid_cleared", 1);
        valid = 28'h0000010; tick("mid_rehit");
        valid = '0; ticks("mid_rehit", 3);

        // Async reset between edges while stalled.
        do_clear();
        out_ready = 1'b0; valid = 28'h1; tick("stall");
        valid = '0; ticks("stall", 2);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("areset.out_valid", 64'(out_valid), 64'd0);
        chk("areset.out_index", out_index, 64'd0);
        chk("areset.covered_count", 64'(covered_count), 64'd0);
        chk("areset.busy", 64'(busy), 64'd0);
        tick("areset_hold");
        reset = 1'b0; out_ready = 1'b1;

        // Enable gating.
        enable = 1'b0; valid = 28'h1;
        ticks("gated", 4);
        enable = 1'b1; valid = '0;
        ticks("gated", 2);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            valid     = ($urandom_range(0, 3) == 0) ? (W'($urandom) & W'($urandom)) : '0;
            enable    = ($urandom_range(0, 7) != 0);
            clear     = ($urandom_range(0, 79) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick("rand");
        end
        clear = 1'b0; valid = '0; out_ready = 1'b1;
        ticks("rand_drain", 32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
